// File: rtl/ext_intr_if.sv
// ----------------------------------------------------------------------------
// ext_intr_if
//   Processor-side bundle of the external-interrupt conditioner.
//
//   Signals:
//     intr_ack       [1:0] INTERRUPT_0 acknowledge (01 = accepted, 10 = return)
//     clr_overrun          single-cycle pulse clearing the overrun flag
//     external_intrp       level interrupt request to the processor
//     event_count    [7:0] saturating count of accepted interrupts
//     overrun              sticky "event lost while busy" flag
//
//   Modports:
//     master  processor / host side (drives acknowledge and clear)
//     slave   conditioner side (drives request, count and flag)
// ----------------------------------------------------------------------------
interface ext_intr_if;
  logic [1:0] intr_ack;
  logic       clr_overrun;
  logic       external_intrp;
  logic [7:0] event_count;
  logic       overrun;

  modport master (
    output intr_ack,
    output clr_overrun,
    input  external_intrp,
    input  event_count,
    input  overrun
  );

  modport slave (
    input  intr_ack,
    input  clr_overrun,
    output external_intrp,
    output event_count,
    output overrun
  );
endinterface

// File: rtl/ext_intr_conditioner.sv
// ----------------------------------------------------------------------------
// ext_intr_conditioner
//   Turns a raw, bouncing external line into a level interrupt request for the
//   processor's INTERRUPT_0 port. The line is synchronised (two flops),
//   debounced (DEBOUNCE_CYCLES stable cycles), edge-detected, and then held as
//   a request until the processor acknowledges and returns from its handler.
//   Accepted events are counted (saturating); events that arrive while a
//   request is outstanding or being serviced set a sticky overrun flag.
//
//   Ports:
//     sys_clk   system clock, all logic on its rising edge
//     ext_rst   synchronous active-high reset
//     btn_raw   asynchronous raw external line
//     bus       ext_intr_if.slave: intr_ack, clr_overrun in;
//               external_intrp, event_count, overrun out
//     btn_db    debounced level, for observation
//
//   Latency from the first sys_clk edge that samples a new btn_raw level to
//   external_intrp high is DEBOUNCE_CYCLES+4 cycles:
//   2 (synchroniser) + DEBOUNCE_CYCLES (debounce) + 1 (edge) + 1 (FSM).
//   DEBOUNCE_CYCLES must be at least 2.
// ----------------------------------------------------------------------------
module ext_intr_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          RISING_EDGE     = 1'b1,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             sys_clk,
  input  logic             ext_rst,
  input  logic             btn_raw,
  ext_intr_if.slave        bus,
  output logic             btn_db
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PENDING    = 2'd1,
    IN_SERVICE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchroniser and debounce
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;

  // Edge detect
  logic             db_dly_q, db_dly_d;
  logic             edge_q, edge_d;

  // Interrupt FSM and its registered outputs
  state_e           state_q, state_d;
  logic             intrp_q, intrp_d;
  logic [7:0]       count_q, count_d;
  logic             overrun_q, overrun_d;

  // NOTE: every signal assigned in this block gets a default at the top, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    s1_d      = btn_raw;
    s2_d      = s1_q;
    cnt_d     = cnt_q;
    db_d      = db_q;
    db_dly_d  = db_q;
    state_d   = state_q;
    intrp_d   = intrp_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    // Debounce: any sample that matches the accepted level restarts the count,
    // so only an uninterrupted run of DEBOUNCE_CYCLES differing samples flips it.
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      db_d  = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    edge_d = RISING_EDGE ? (db_q & ~db_dly_q) : (~db_q & db_dly_q);

    // Clear first, so an overrun-setting edge below in the same cycle wins.
    if (bus.clr_overrun) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (edge_q) begin
          state_d = PENDING;
          intrp_d = 1'b1;
          if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end
        end
      end

      PENDING: begin
        if (edge_q) begin
          overrun_d = 1'b1;
        end
        if (bus.intr_ack == 2'b01) begin
          state_d = IN_SERVICE;
          intrp_d = 1'b0;
        end
      end

      IN_SERVICE: begin
        // An edge in the cycle we leave for IDLE is still lost: it is judged
        // against the current state, not the next one.
        if (edge_q) begin
          overrun_d = 1'b1;
        end
        if (bus.intr_ack == 2'b10) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        intrp_d = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before this clock edge, independent of statement order.
  always_ff @(posedge sys_clk) begin
    if (ext_rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      db_q      <= 1'b0;
      db_dly_q  <= 1'b0;
      edge_q    <= 1'b0;
      state_q   <= IDLE;
      intrp_q   <= 1'b0;
      count_q   <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_dly_q  <= db_dly_d;
      edge_q    <= edge_d;
      state_q   <= state_d;
      intrp_q   <= intrp_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.external_intrp = intrp_q;
  assign bus.event_count    = count_q;
  assign bus.overrun        = overrun_q;
  assign btn_db             = db_q;

endmodule

// File: tb/tb_ext_intr_conditioner.sv
// ----------------------------------------------------------------------------
// tb_ext_intr_conditioner
//   Directed bench for ext_intr_conditioner with DEBOUNCE_CYCLES = 16.
//   Inputs change 1 time unit after a rising edge; outputs are read at the same
//   point, so "after edge k" below means the value registered on edge k.
// ----------------------------------------------------------------------------
module tb_ext_intr_conditioner;

  localparam int unsigned D = 16;

  logic sys_clk;
  logic ext_rst;
  logic btn_raw;
  logic btn_db;

  int n_checks = 0;
  int n_fail   = 0;

  ext_intr_if bus ();

  ext_intr_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .RISING_EDGE     (1'b1)
  ) dut (
    .sys_clk (sys_clk),
    .ext_rst (ext_rst),
    .btn_raw (btn_raw),
    .bus     (bus),
    .btn_db  (btn_db)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Reset with the line idle low, so no event is produced afterwards.
  task automatic do_reset();
    btn_raw         = 1'b0;
    bus.intr_ack    = 2'b00;
    bus.clr_overrun = 1'b0;
    ext_rst         = 1'b1;
    tick(2);
    ext_rst = 1'b0;
  endtask

  // Full accept + return-from-handler sequence.
  task automatic do_ack();
    bus.intr_ack = 2'b01;
    tick();
    bus.intr_ack = 2'b10;
    tick();
    bus.intr_ack = 2'b00;
  endtask

  // Drop the line and wait until the debounced level has settled low.
  task automatic release_btn();
    btn_raw = 1'b0;
    tick(D + 6);
  endtask

  task automatic test_reset();
    ext_rst         = 1'b1;
    btn_raw         = 1'b1;
    bus.intr_ack    = 2'b00;
    bus.clr_overrun = 1'b0;
    tick(3);
    n_checks++; if (bus.external_intrp !== 1'b0) begin n_fail++; $display("FAIL reset_intrp: got %b want 0", bus.external_intrp); end
    n_checks++; if (bus.event_count !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h want 00", bus.event_count); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    n_checks++; if (btn_db !== 1'b0) begin n_fail++; $display("FAIL reset_btn_db: got %b want 0", btn_db); end
    ext_rst = 1'b0;
    tick(D + 1);
    n_checks++; if (btn_db !== 1'b0) begin n_fail++; $display("FAIL reset_db_early: got %b want 0 at cycle 17", btn_db); end
    tick();
    n_checks++; if (btn_db !== 1'b1) begin n_fail++; $display("FAIL reset_db_rise: got %b want 1 at cycle 18", btn_db); end
    n_checks++; if (bus.external_intrp !== 1'b0) begin n_fail++; $display("FAIL reset_intrp_18: got %b want 0", bus.external_intrp); end
    tick();
    n_checks++; if (bus.external_intrp !== 1'b0) begin n_fail++; $display("FAIL reset_intrp_19: got %b want 0", bus.external_intrp); end
    tick();
    n_checks++; if (bus.external_intrp !== 1'b1) begin n_fail++; $display("FAIL reset_intrp_20: got %b want 1", bus.external_intrp); end
    n_checks++; if (bus.event_count !== 8'h01) begin n_fail++; $display("FAIL reset_count_20: got %h want 01", bus.event_count); end
    do_ack();
    release_btn();
  endtask

  task automatic test_bounce();
    logic saw_db;
    logic saw_intrp;
    do_reset();
    saw_db    = 1'b0;
    saw_intrp = 1'b0;
    for (int seg = 0; seg < 20; seg++) begin
      btn_raw = (seg % 2 == 0) ? 1'b1 : 1'b0;
      for (int c = 0; c < 5; c++) begin
        tick();
        saw_db    = saw_db | btn_db;
        saw_intrp = saw_intrp | bus.external_intrp;
      end
    end
    n_checks++; if (saw_db !== 1'b0) begin n_fail++; $display("FAIL bounce_db_glitch: got %b want 0", saw_db); end
    n_checks++; if (saw_intrp !== 1'b0) begin n_fail++; $display("FAIL bounce_intrp_glitch: got %b want 0", saw_intrp); end
    btn_raw = 1'b1;
    tick(D + 1);
    n_checks++; if (btn_db !== 1'b0) begin n_fail++; $display("FAIL bounce_db_17: got %b want 0", btn_db); end
    tick();
    n_checks++; if (btn_db !== 1'b1) begin n_fail++; $display("FAIL bounce_db_18: got %b want 1", btn_db); end
    tick(2);
    n_checks++; if (bus.external_intrp !== 1'b1) begin n_fail++; $display("FAIL bounce_intrp: got %b want 1", bus.external_intrp); end
    n_checks++; if (bus.event_count !== 8'h01) begin n_fail++; $display("FAIL bounce_count: got %h want 01", bus.event_count); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL bounce_overrun: got %b want 0", bus.overrun); end
    do_ack();
    release_btn();
  endtask

  task automatic test_handshake();
    do_reset();
    btn_raw = 1'b1;
    tick(D + 4);
    n_checks++; if (bus.external_intrp !== 1'b1) begin n_fail++; $display("FAIL hs_intrp_rise: got %b want 1", bus.external_intrp); end
    tick(3);
    n_checks++; if (bus.external_intrp !== 1'b1) begin n_fail++; $display("FAIL hs_intrp_held: got %b want 1", bus.external_intrp); end
    bus.intr_ack = 2'b01;
    tick();
    bus.intr_ack = 2'b00;
    n_checks++; if (bus.external_intrp !== 1'b0) begin n_fail++; $display("FAIL hs_intrp_drop: got %b want 0", bus.external_intrp); end
    tick(3);
    n_checks++; if (bus.external_intrp !== 1'b0) begin n_fail++; $display("FAIL hs_in_service: got %b want 0", bus.external_intrp); end
    bus.intr_ack = 2'b10;
    tick();
    bus.intr_ack = 2'b00;
    release_btn();
    btn_raw = 1'b1;
    tick(D + 4);
    n_checks++; if (bus.external_intrp !== 1'b1) begin n_fail++; $display("FAIL hs_second_intrp: got %b want 1", bus.external_intrp); end
    n_checks++; if (bus.event_count !== 8'h02) begin n_fail++; $display("FAIL hs_second_count: got %h want 02", bus.event_count); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL hs_overrun: got %b want 0", bus.overrun); end
    do_ack();
    release_btn();
  endtask

  task automatic test_overrun();
    do_reset();
    btn_raw = 1'b1;
    tick(D + 4);
    release_btn();
    // Second press while still PENDING.
    btn_raw = 1'b1;
    tick(D + 3);
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early: got %b want 0", bus.overrun); end
    tick();
    n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", bus.overrun); end
    n_checks++; if (bus.event_count !== 8'h01) begin n_fail++; $display("FAIL ovr_count: got %h want 01", bus.event_count); end
    n_checks++; if (bus.external_intrp !== 1'b1) begin n_fail++; $display("FAIL ovr_intrp: got %b want 1", bus.external_intrp); end
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", bus.overrun); end
    release_btn();
    // Third press: clear lands on the same cycle the lost edge is seen.
    btn_raw = 1'b1;
    tick(D + 3);
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;
    n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b want 1", bus.overrun); end
    n_checks++; if (bus.event_count !== 8'h01) begin n_fail++; $display("FAIL ovr_count2: got %h want 01", bus.event_count); end
    // Edge lost while IN_SERVICE.
    bus.intr_ack = 2'b01;
    tick();
    bus.intr_ack    = 2'b00;
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;
    release_btn();
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear2: got %b want 0", bus.overrun); end
    btn_raw = 1'b1;
    tick(D + 4);
    n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_in_service: got %b want 1", bus.overrun); end
    n_checks++; if (bus.external_intrp !== 1'b0) begin n_fail++; $display("FAIL ovr_in_service_intrp: got %b want 0", bus.external_intrp); end
    n_checks++; if (bus.event_count !== 8'h01) begin n_fail++; $display("FAIL ovr_in_service_count: got %h want 01", bus.event_count); end
    bus.intr_ack = 2'b10;
    tick();
    bus.intr_ack = 2'b00;
    release_btn();
  endtask

  task automatic test_saturation();
    logic [7:0] exp_cnt;
    do_reset();
    exp_cnt = 8'h00;
    for (int i = 0; i < 260; i++) begin
      btn_raw = 1'b1;
      tick(D + 4);
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      n_checks++; if (bus.external_intrp !== 1'b1 || bus.event_count !== exp_cnt) begin
        n_fail++;
        $display("FAIL sat_press_%0d: got intrp=%b count=%h want intrp=1 count=%h", i, bus.external_intrp, bus.event_count, exp_cnt);
      end
      do_ack();
      btn_raw = 1'b0;
      tick(D + 4);
    end
    n_checks++; if (bus.event_count !== 8'hFF) begin n_fail++; $display("FAIL sat_final: got %h want ff", bus.event_count); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL sat_overrun: got %b want 0", bus.overrun); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    btn_raw = 1'b1;
    tick(D + 4);
    n_checks++; if (bus.external_intrp !== 1'b1) begin n_fail++; $display("FAIL rmid_pending: got %b want 1", bus.external_intrp); end
    ext_rst = 1'b1;
    tick();
    n_checks++; if (bus.external_intrp !== 1'b0) begin n_fail++; $display("FAIL rmid_intrp: got %b want 0", bus.external_intrp); end
    n_checks++; if (bus.event_count !== 8'h00) begin n_fail++; $display("FAIL rmid_count: got %h want 00", bus.event_count); end
    n_checks++; if (btn_db !== 1'b0) begin n_fail++; $display("FAIL rmid_db: got %b want 0", btn_db); end
    btn_raw = 1'b0;
    ext_rst = 1'b0;
    tick(2 * D + 8);
    n_checks++; if (bus.external_intrp !== 1'b0 || bus.event_count !== 8'h00) begin
      n_fail++;
      $display("FAIL rmid_spurious: got intrp=%b count=%h want intrp=0 count=00", bus.external_intrp, bus.event_count);
    end
    // Abort part way through a debounce.
    btn_raw = 1'b1;
    tick(10);
    ext_rst = 1'b1;
    tick();
    btn_raw = 1'b0;
    ext_rst = 1'b0;
    tick(2 * D + 8);
    n_checks++; if (bus.external_intrp !== 1'b0 || bus.event_count !== 8'h00 || btn_db !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_debounce_abort: got intrp=%b count=%h db=%b want 0/00/0", bus.external_intrp, bus.event_count, btn_db);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_handshake();
    test_overrun();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
